// File: rtl/sram_bus_ctrl.sv
// MEM-side responder for an asynchronous 32-bit SRAM.
// Runs setup/access/done cycles per request; every output is registered.
module sram_bus_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_ready_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dq_q, dq_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              oor;
  logic [7:0]        last;

  assign oor  = (mem_addr_i >> (ADDR_W + 2)) != 32'd0;
  assign last = we_q ? 8'(WR_WAIT - 1) : 8'(RD_WAIT - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    err_d   = err_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    be_n_d  = be_n_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_ce_i) begin
          we_d = mem_we_i;
          if (oor) begin
            // Out-of-range: answer immediately, never touch the pins
            state_d = S_DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
            if (!mem_we_i) rdata_d = 32'd0;
          end else begin
            state_d = S_SETUP;
            addr_d  = mem_addr_i[ADDR_W+1:2];
            ce_n_d  = 1'b0;
            if (mem_we_i) begin
              dq_oe_d = 1'b1;
              dq_d    = mem_data_i;
              be_n_d  = ~mem_sel_i;
            end else begin
              oe_n_d = 1'b0;
              be_n_d = 4'h0;
            end
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = 8'd0;
        if (we_q) we_n_d = 1'b0;
      end
      S_ACCESS: begin
        if (cnt_q == last) begin
          state_d = S_DONE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          be_n_d  = 4'hF;
          ready_d = 1'b1;
          if (!we_q) rdata_d = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        err_d   = 1'b0;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dq_q    <= 32'd0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign mem_data_o  = rdata_q;
  assign mem_ready_o = ready_q;
  assign bus_err_o   = err_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = dq_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: async SRAM device model plus a
// word-array reference model of MEM-visible results and pin timing.
module tb_sram_bus_ctrl;

  localparam int AW = 20;
  localparam int RD = 2;
  localparam int WR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_ce_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [31:0]   mem_addr_i = '0;
  logic [3:0]    mem_sel_i = '0;
  logic [31:0]   mem_data_i = '0;
  logic [31:0]   mem_data_o;
  logic          mem_ready_o;
  logic          bus_err_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_dq_o;
  logic [31:0]   sram_dq_i;
  logic          sram_dq_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sram_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  sram_bus_ctrl #(.ADDR_W(AW), .RD_WAIT(RD), .WR_WAIT(WR)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_ready_o(mem_ready_o), .bus_err_o(bus_err_o),
    .sram_addr_o(sram_addr_o), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // Device model; it powers up cleared whenever rst is seen
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n)
                     ? sram_mem[sram_addr_o[9:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= 32'd0;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b])
          sram_mem[sram_addr_o[9:0]][8*b+:8] <= sram_dq_o[8*b+:8];
    end
  end

  function automatic int rmask(int lo, int hi);
    int m = 0;
    for (int i = lo; i <= hi; i++) m |= (1 << i);
    return m;
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    last_rd = 32'd0;
  endtask

  // Issues one request (ce high for one cycle) and records the pins per cycle
  task automatic run_txn(
    input  logic we, input logic [31:0] a,
    input  logic [3:0] sel, input logic [31:0] d,
    output int rc, output logic err, output logic [31:0] rd,
    output int ce_m, output int oe_m, output int we_m, output int dq_m,
    output logic [AW-1:0] a1, output logic [3:0] be1,
    output logic stable, output logic dbl);
    rc = -1; err = 0; rd = 0; ce_m = 0; oe_m = 0; we_m = 0; dq_m = 0;
    a1 = '0; be1 = '0; stable = 1; dbl = 0;
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = we; mem_addr_i = a;
    mem_sel_i = sel; mem_data_i = d;
    @(posedge clk); #1;
    mem_ce_i = 0;
    mem_we_i = 1'($urandom); mem_addr_i = $urandom;
    mem_sel_i = 4'($urandom); mem_data_i = $urandom;
    for (int c = 1; c <= 24 && rc < 0; c++) begin
      if (!sram_ce_n) ce_m |= (1 << c);
      if (!sram_oe_n) oe_m |= (1 << c);
      if (!sram_we_n) we_m |= (1 << c);
      if (sram_dq_oe) dq_m |= (1 << c);
      if (c == 1) begin a1 = sram_addr_o; be1 = sram_be_n; end
      if (!sram_ce_n && sram_addr_o !== a[AW+1:2]) stable = 0;
      if (sram_dq_oe && sram_dq_o !== d) stable = 0;
      if (mem_ready_o) begin
        rc = c; err = bus_err_o; rd = mem_data_o;
      end
      @(posedge clk); #1;
    end
    dbl = mem_ready_o;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_ready_o, bus_err_o, sram_dq_oe, sram_ce_n, sram_oe_n,
         sram_we_n, sram_be_n} !== 10'b000_111_1111) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 0001111111",
               {mem_ready_o, bus_err_o, sram_dq_oe, sram_ce_n,
                sram_oe_n, sram_we_n, sram_be_n});
    end
    n_cmp++;
    if (mem_data_o !== 32'd0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", mem_data_o);
    end
    n_cmp++;
    if (sram_addr_o !== '0) begin
      n_bad++; $display("FAIL reset_addr got %h want 0", sram_addr_o);
    end
    n_cmp++;
    if (sram_dq_o !== 32'd0) begin
      n_bad++; $display("FAIL reset_dq got %h want 0", sram_dq_o);
    end
    clear_ref();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_directed();
    int rc, cm, om, wm, dm;
    logic err, st, db;
    logic [31:0] rd;
    logic [AW-1:0] a1;
    logic [3:0] be1;
    run_txn(1, 32'h100, 4'hF, 32'hDEADBEEF,
            rc, err, rd, cm, om, wm, dm, a1, be1, st, db);
    n_cmp++;
    if (rc !== 4) begin
      n_bad++; $display("FAIL sw_latency got %0d want 4", rc);
    end
    run_txn(0, 32'h100, 4'h0, 32'h0,
            rc, err, rd, cm, om, wm, dm, a1, be1, st, db);
    n_cmp++;
    if (a1 !== 20'h40) begin
      n_bad++; $display("FAIL lw_addr got %h want 40", a1);
    end
    n_cmp++;
    if (om !== rmask(1, 3) || wm !== 0) begin
      n_bad++; $display("FAIL lw_strobes oe %h we %h want %h 0",
                        om, wm, rmask(1, 3));
    end
    n_cmp++;
    if (rc !== 4 || rd !== 32'hDEADBEEF || err !== 0) begin
      n_bad++; $display("FAIL lw_result cyc %0d data %h err %b want 4 deadbeef 0",
                        rc, rd, err);
    end
    run_txn(1, 32'h203, 4'b0100, 32'h5A5A5A5A,
            rc, err, rd, cm, om, wm, dm, a1, be1, st, db);
    n_cmp++;
    if (a1 !== 20'h80 || be1 !== 4'b1011) begin
      n_bad++; $display("FAIL sb_addr_be got %h %b want 80 1011", a1, be1);
    end
    n_cmp++;
    if (wm !== rmask(2, 3) || dm !== rmask(1, 4) || om !== 0) begin
      n_bad++; $display("FAIL sb_strobes we %h dq %h oe %h want %h %h 0",
                        wm, dm, om, rmask(2, 3), rmask(1, 4));
    end
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sb_holds_rdata got %h want deadbeef", rd);
    end
    run_txn(0, 32'h0040_0000, 4'h0, 32'h0,
            rc, err, rd, cm, om, wm, dm, a1, be1, st, db);
    n_cmp++;
    if (rc !== 1 || err !== 1 || rd !== 32'd0) begin
      n_bad++; $display("FAIL oor_read cyc %0d err %b data %h want 1 1 0",
                        rc, err, rd);
    end
    n_cmp++;
    if ((cm | om | wm | dm) !== 0) begin
      n_bad++; $display("FAIL oor_strobes got %h want 0", cm | om | wm | dm);
    end
    ref_mem[10'h40] = 32'hDEADBEEF;
    ref_mem[10'h80] = 32'h005A0000;
    last_rd = 32'd0;
  endtask

  // One generic transaction checked against the reference rules
  task automatic check_txn(input logic we, input logic [31:0] a,
                           input logic [3:0] sel, input logic [31:0] d,
                           input string tag);
    int rc, cm, om, wm, dm, e_rc, e_cm, e_om, e_wm, e_dm;
    logic err, st, db, e_err, oob;
    logic [31:0] rd, e_rd;
    logic [AW-1:0] a1;
    logic [3:0] be1;
    logic [9:0] w;
    oob = (a >> (AW + 2)) != 0;
    w = a[11:2];
    if (oob) begin
      e_rc = 1; e_err = 1; e_rd = we ? last_rd : 32'd0;
      e_cm = 0; e_om = 0; e_wm = 0; e_dm = 0;
    end else if (we) begin
      e_rc = WR + 2; e_err = 0; e_rd = last_rd;
      e_cm = rmask(1, WR + 1); e_om = 0;
      e_wm = rmask(2, WR + 1); e_dm = rmask(1, WR + 2);
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w][8*b+:8] = d[8*b+:8];
    end else begin
      e_rc = RD + 2; e_err = 0; e_rd = ref_mem[w];
      e_cm = rmask(1, RD + 1); e_om = e_cm; e_wm = 0; e_dm = 0;
    end
    last_rd = e_rd;
    run_txn(we, a, sel, d, rc, err, rd, cm, om, wm, dm, a1, be1, st, db);
    n_cmp++;
    if (rc !== e_rc || err !== e_err || rd !== e_rd) begin
      n_bad++;
      $display("FAIL %s a=%h we=%b cyc/err/data %0d %b %h want %0d %b %h",
               tag, a, we, rc, err, rd, e_rc, e_err, e_rd);
    end
    n_cmp++;
    if (cm !== e_cm || om !== e_om || wm !== e_wm || dm !== e_dm) begin
      n_bad++;
      $display("FAIL %s_pins a=%h ce %h oe %h we %h dq %h want %h %h %h %h",
               tag, a, cm, om, wm, dm, e_cm, e_om, e_wm, e_dm);
    end
    n_cmp++;
    if (st !== 1 || db !== 0) begin
      n_bad++; $display("FAIL %s_hold a=%h stable %b dbl %b want 1 0",
                        tag, a, st, db);
    end
    if (!oob) begin
      n_cmp++;
      if (a1 !== AW'(w) || be1 !== (we ? ~sel : 4'h0)) begin
        n_bad++; $display("FAIL %s_setup addr %h be %b want %h %b",
                          tag, a1, be1, w, we ? ~sel : 4'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a = {22'd0, 8'($urandom), 2'b00};
    logic [31:0] d = $urandom;
    check_txn(0, a, 4'h0, 32'h0, "b2b_lw1");
    check_txn(1, a, 4'hF, d, "b2b_sw");
    check_txn(0, a, 4'h0, 32'h0, "b2b_lw2");
  endtask

  task automatic test_random();
    logic we;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0040_0000;
      else a = {22'd0, 8'($urandom), 2'($urandom)};
      check_txn(we, a, 4'($urandom), $urandom, "rand");
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'hFFC;
    mem_sel_i = 4'hF; mem_data_i = $urandom;
    @(posedge clk); #1;
    mem_ce_i = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (sram_we_n !== 0) begin
      n_bad++; $display("FAIL rstmid_pre we_n got %b want 0", sram_we_n);
    end
    rst = 1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sram_we_n, sram_dq_oe, mem_ready_o, sram_ce_n} !== 4'b1001) begin
      n_bad++; $display("FAIL rstmid_pins got %b want 1001",
                        {sram_we_n, sram_dq_oe, mem_ready_o, sram_ce_n});
    end
    rst = 0;
    clear_ref();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_ready_o) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL rstmid_no_ready got 1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
